// File: rtl/sum_drain_pkg.sv
// Shared types and default constants for the sum_drain token drain.
package sum_drain_pkg;

  localparam int unsigned W_DEF     = 11;
  localparam int unsigned LIMIT_DEF = 150;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sum_drain_ctr.sv
// Paired remaining/delivered counters for sum_drain.
// load clears the delivered count and seeds the remaining count; step moves
// one token from remaining to delivered; otherwise both hold.
module sum_drain_ctr
  import sum_drain_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         step_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] cnt_q, cnt_d;

  // Next-state selection: load wins over step; step never underflows rem.
  always_comb begin
    rem_d = rem_q;
    cnt_d = cnt_q;
    if (load_i) begin
      rem_d = val_i;
      cnt_d = '0;
    end else if (step_i && (rem_q != '0)) begin
      rem_d = rem_q - 1'b1;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

  assign rem_o = rem_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/sum_drain.sv
// sum_drain: loads a clamped token total and hands tokens out one per
// accepted cycle (valid && ready) until exhausted, then parks in DONE.
// Optional macro SUM_DRAIN_ASSERT_EN compiles in concurrent property checks.
module sum_drain
  import sum_drain_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned LIMIT = LIMIT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] rem,
  output logic [W-1:0] cnt,
  output logic [W-1:0] total,
  output logic         busy,
  output logic         done
);

  localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

  state_e       state_q;
  logic [W-1:0] total_q;
  logic [W-1:0] clamp_val;
  logic         ctr_load;
  logic         ctr_step;

  assign clamp_val = (load_val > LIMIT_W) ? LIMIT_W : load_val;
  assign ctr_load  = load && (state_q != DRAIN);
  assign ctr_step  = ready && (state_q == DRAIN);

  sum_drain_ctr #(.W(W)) u_ctr (
    .clk    (clk),
    .rst    (rst),
    .load_i (ctr_load),
    .val_i  (clamp_val),
    .step_i (ctr_step),
    .rem_o  (rem),
    .cnt_o  (cnt)
  );

  // Control FSM and captured total; load is only honoured outside DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      total_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (load) begin
            total_q <= clamp_val;
            state_q <= (clamp_val != '0) ? DRAIN : DONE;
          end
        end
        DRAIN: begin
          if (ready && (rem == W'(1))) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valid = (state_q == DRAIN);
  assign busy  = (state_q == DRAIN);
  assign done  = (state_q == DONE);
  assign total = total_q;

`ifdef SUM_DRAIN_ASSERT_EN
  a_sum_inv : assert property (@(posedge clk) disable iff (rst)
    (rem + cnt) == total);
  a_cnt_lim : assert property (@(posedge clk) disable iff (rst)
    cnt <= LIMIT_W);
  a_valid_rem : assert property (@(posedge clk) disable iff (rst)
    valid |-> (rem != '0));
  a_done_state : assert property (@(posedge clk) disable iff (rst)
    done |-> ((rem == '0) && (cnt == total)));
  a_stall_hold : assert property (@(posedge clk) disable iff (rst)
    (valid && !ready) |=> $stable(rem));
`endif

endmodule
